// File: rtl/mcss_column_feeder.sv
// Packs 32-bit words into IMG_ROWS-word columns for the MCSS reducer (strobe 1 cycle after the column's last word) and reports per-frame best/column count.
// in_ready drops from in_last until all issued columns have results back; define MCSS_FEEDER_PAD_EN to zero-pad a short final column instead of flagging err_partial.
module mcss_column_feeder #(
    parameter int IMG_ROWS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_data,
    input  logic                   in_last,
    output logic                   out_en,
    output logic [IMG_ROWS*32-1:0] out_arr,
    input  logic                   res_valid,
    input  logic [31:0]            res_data,
    output logic                   frame_done,
    output logic [31:0]            frame_best,
    output logic [CNT_W-1:0]       frame_cols,
    output logic                   err_partial
);

    localparam int               ROW_W     = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_ROWS - 1);
    localparam logic [31:0]      BEST_INIT = 32'h8000_0000;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ROW_W-1:0]        row_q;
    logic [31:0]             slot_q [IMG_ROWS];
    logic                    out_en_q;
    logic [IMG_ROWS*32-1:0]  out_arr_q;
    logic [IMG_ROWS*32-1:0]  col_d;
    logic [CNT_W-1:0]        issued_q;
    logic [CNT_W-1:0]        received_q, received_d;
    logic [31:0]             best_q, best_d;
    logic                    frame_done_q;
    logic [31:0]             frame_best_q;
    logic [CNT_W-1:0]        frame_cols_q;
    logic                    err_q;

    logic accept;
    logic at_end;
    logic col_done;
    logic part_end;
    logic issue;
    logic err_set;
    logic drain_exit;

    assign accept   = in_valid && in_ready;
    assign at_end   = (row_q == ROW_LAST);
    assign col_done = accept && at_end;
    assign part_end = accept && in_last && !at_end;

`ifdef MCSS_FEEDER_PAD_EN
    assign issue   = col_done || part_end;
    assign err_set = 1'b0;
`else
    assign issue   = col_done;
    assign err_set = part_end;
`endif

    // Results arriving this cycle count toward the drain check and the running best.
    assign received_d = received_q + CNT_W'(res_valid);
    assign best_d     = (res_valid && ($signed(res_data) > $signed(best_q))) ? res_data : best_q;
    assign drain_exit = (state_q == S_DRAIN) && (received_d == issued_q);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FILL:  if (accept && in_last) state_d = S_DRAIN;
            S_DRAIN: if (drain_exit)        state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            S_FILL:  in_ready = 1'b1;
            S_DRAIN: in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
    end

    // Rows below the current one come from the shadow slots, the current row from
    // the incoming word, and anything above is zero (only reachable when padding).
    always_comb begin
        col_d = '0;
        for (int j = 0; j < IMG_ROWS; j++) begin
            if (ROW_W'(j) < row_q) begin
                col_d[j*32 +: 32] = slot_q[j];
            end else if (ROW_W'(j) == row_q) begin
                col_d[j*32 +: 32] = in_data;
            end else begin
                col_d[j*32 +: 32] = 32'h0;
            end
        end
    end

    // ---------------- column assembly and issue ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q     <= '0;
            out_en_q  <= 1'b0;
            out_arr_q <= '0;
            for (int j = 0; j < IMG_ROWS; j++) begin
                slot_q[j] <= 32'h0;
            end
        end else begin
            out_en_q <= issue;
            if (issue) begin
                out_arr_q <= col_d;
            end
            if (accept) begin
                slot_q[row_q] <= in_data;
                row_q         <= in_last ? '0 : row_q + ROW_W'(1);
            end
        end
    end

    // ---------------- result collection and frame report ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q     <= '0;
            received_q   <= '0;
            best_q       <= BEST_INIT;
            frame_done_q <= 1'b0;
            frame_best_q <= 32'h0;
            frame_cols_q <= '0;
        end else begin
            frame_done_q <= drain_exit;
            if (drain_exit) begin
                frame_best_q <= best_d;
                frame_cols_q <= issued_q;
                issued_q     <= '0;
                received_q   <= '0;
                best_q       <= BEST_INIT;
            end else begin
                received_q <= received_d;
                best_q     <= best_d;
                if (issue) begin
                    issued_q <= issued_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign out_en      = out_en_q;
    assign out_arr     = out_arr_q;
    assign frame_done  = frame_done_q;
    assign frame_best  = frame_best_q;
    assign frame_cols  = frame_cols_q;
    assign err_partial = err_q;

endmodule

// File: tb/tb_mcss_column_feeder.sv
// Bench for mcss_column_feeder: word-queue model plus an MCSS reducer responder, checked every cycle, with literal frame expectations.
module tb_mcss_column_feeder;

    localparam int          ROWS = 4;
    localparam int          CW   = 16;
    localparam logic [31:0] MINV = 32'h8000_0000;
`ifdef MCSS_FEEDER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_data = 32'h0;
    logic              in_last = 1'b0;
    logic              out_en;
    logic [ROWS*32-1:0] out_arr;
    logic              res_valid = 1'b0;
    logic [31:0]       res_data = 32'h0;
    logic              frame_done;
    logic [31:0]       frame_best;
    logic [CW-1:0]     frame_cols;
    logic              err_partial;

    mcss_column_feeder #(.IMG_ROWS(ROWS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_en(out_en), .out_arr(out_arr),
        .res_valid(res_valid), .res_data(res_data),
        .frame_done(frame_done), .frame_best(frame_best), .frame_cols(frame_cols),
        .err_partial(err_partial)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Maximum non-empty contiguous sum of the column rows.
    function automatic logic [31:0] mcss(input logic [127:0] v);
        int best, cur, x;
        best = int'(v[31:0]);
        cur  = best;
        for (int j = 1; j < ROWS; j++) begin
            x    = int'(v[j*32 +: 32]);
            cur  = (cur + x > x) ? cur + x : x;
            best = (cur > best) ? cur : best;
        end
        return 32'(best);
    endfunction

    function automatic logic [127:0] col4(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    // ---------------- reducer responder ----------------
    typedef struct {
        int          due;
        logic [31:0] val;
    } res_t;
    res_t rq[$];
    int   cyc = 0;
    int   red_lat = 1;

    always @(negedge clk or negedge rst_n) begin
        res_t r;
        if (!rst_n) begin
            rq.delete();
            res_valid = 1'b0;
            res_data  = 32'h0;
        end else begin
            cyc++;
            res_valid = 1'b0;
            res_data  = 32'h0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                r         = rq.pop_front();
                res_valid = 1'b1;
                res_data  = r.val;
            end
            if (out_en) begin
                r.due = cyc + red_lat;
                r.val = mcss(out_arr);
                rq.push_back(r);
            end
        end
    end

    // ---------------- behavioural model ----------------
    logic [31:0]  wq[$];
    bit           m_drain, m_en, m_done, m_err;
    logic [127:0] m_col;
    logic [31:0]  m_best_rep, run_best;
    int           m_cols_rep, iss, rcv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq.delete();
            m_drain = 0; m_en = 0; m_done = 0; m_err = 0;
            m_col = '0; m_best_rep = 32'h0; m_cols_rep = 0;
            run_best = MINV; iss = 0; rcv = 0;
        end else begin
            m_en   = 0;
            m_done = 0;
            if (res_valid) begin
                rcv++;
                if ($signed(res_data) > $signed(run_best)) run_best = res_data;
            end
            if (m_drain) begin
                if (rcv == iss) begin
                    m_done     = 1;
                    m_best_rep = run_best;
                    m_cols_rep = iss;
                    run_best   = MINV;
                    iss        = 0;
                    rcv        = 0;
                    m_drain    = 0;
                end
            end else if (in_valid) begin
                wq.push_back(in_data);
                if (wq.size() == ROWS || in_last) begin
                    if (wq.size() == ROWS || PAD) begin
                        while (wq.size() < ROWS) wq.push_back(32'h0);
                        for (int j = 0; j < ROWS; j++) m_col[j*32 +: 32] = wq[j];
                        m_en = 1;
                        iss++;
                    end else begin
                        m_err = 1;
                    end
                    wq.delete();
                    if (in_last) m_drain = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            chk("in_ready", in_ready, !m_drain);
            chk("out_en", out_en, m_en);
            if (m_en) chk("out_arr", out_arr, m_col);
            chk("frame_done", frame_done, m_done);
            chk("frame_best", frame_best, m_best_rep);
            chk("frame_cols", frame_cols, 16'(m_cols_rep));
            chk("err_partial", err_partial, m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int d, input bit l);
        int g = 0;
        in_valid = 1'b1;
        in_data  = 32'(d);
        in_last  = l;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("send ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string nm, input logic [31:0] eb, input int ec);
        int g = 0;
        while (frame_done !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk({nm, " done seen"}, frame_done, 1);
        chk({nm, " best"}, frame_best, eb);
        chk({nm, " cols"}, frame_cols, 16'(ec));
        chk({nm, " ready at done"}, in_ready, 1);
        @(negedge clk);
        chk({nm, " single pulse"}, frame_done, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst out_en", out_en, 0);
        chk("rst out_arr", out_arr, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst frame_best", frame_best, 0);
        chk("rst frame_cols", frame_cols, 0);
        chk("rst err", err_partial, 0);
        chk("rst in_ready", in_ready, 1);
        rst_n    = 1'b1;
        check_en = 1'b1;

        // single column
        red_lat = 1;
        send(1, 0); send(-2, 0); send(3, 0); send(4, 1);
        chk("t1 out_en", out_en, 1);
        chk("t1 out_arr", out_arr, col4(1, -2, 3, 4));
        wait_done("t1", 32'd7, 1);

        // two columns back-to-back
        send(1, 0); send(-2, 0); send(3, 0); send(4, 0);
        chk("t2 out_en a", out_en, 1);
        send(-1, 0); send(-1, 0); send(-1, 0); send(-1, 1);
        chk("t2 out_en b", out_en, 1);
        chk("t2 out_arr b", out_arr, col4(-1, -1, -1, -1));
        wait_done("t2", 32'd7, 2);

        // all negative
        send(-5, 0); send(-3, 0); send(-8, 0); send(-4, 1);
        wait_done("t3", 32'hFFFF_FFFD, 1);

        // short final column
        send(5, 0); send(-9, 1);
`ifdef MCSS_FEEDER_PAD_EN
        chk("t4 out_en", out_en, 1);
        chk("t4 out_arr", out_arr, col4(5, -9, 0, 0));
        wait_done("t4", 32'd5, 1);
        chk("t4 err", err_partial, 0);
`else
        chk("t4 out_en", out_en, 0);
        wait_done("t4", MINV, 0);
        chk("t4 err", err_partial, 1);
`endif

        // slow reducer
        red_lat = 3;
        send(2, 0); send(2, 0); send(2, 0); send(2, 0);
        send(-7, 0); send(1, 0); send(-7, 0); send(3, 1);
        chk("t5 drain in_ready", in_ready, 0);
        wait_done("t5", 32'd8, 2);

        // reset mid-column
        red_lat = 1;
        send(7, 0); send(8, 0);
        check_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst out_en", out_en, 0);
        chk("t6 rst out_arr", out_arr, 0);
        chk("t6 rst frame_done", frame_done, 0);
        chk("t6 rst frame_best", frame_best, 0);
        chk("t6 rst frame_cols", frame_cols, 0);
        chk("t6 rst err", err_partial, 0);
        chk("t6 rst in_ready", in_ready, 1);
        @(negedge clk);
        rst_n    = 1'b1;
        check_en = 1'b1;
        send(2, 0); send(3, 0); send(-1, 0); send(6, 1);
        chk("t6 out_en", out_en, 1);
        chk("t6 out_arr", out_arr, col4(2, 3, -1, 6));
        wait_done("t6", 32'd10, 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
